packet_sink: RTL and testbench

- Receiving end of the two-phase (toggle) req/ack flit link driven by a packet source.
- Accepts SIZE-bit flits; the MSB of each flit is the head marker (1 = head, 0 = body).
- Reassembles FLITS flits into one packet, checks framing, pulses a packet-valid strobe and asserts done after PACKETS packets.
- Sits at a NoC router output port as a traffic terminator for simulation and test.

---
 rtl/packet_sink.sv | 132 +++++++++++++
 tb/tb_packet_sink.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/packet_sink.sv
// Receiving end of a two-phase req/ack flit link: reassembles FLITS-flit packets and checks head framing.
// Optional PACKET_SINK_STRICT_EN: the first framing/protocol error halts the sink until reset.
module packet_sink #(
  parameter int unsigned ID        = 0,
  parameter int unsigned FLITS     = 8,
  parameter int unsigned SIZE      = 8,
  parameter int unsigned PACKETS   = 2,
  parameter int unsigned ACK_DELAY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [SIZE-1:0]       data,
  output logic                  ack,
  output logic [FLITS*SIZE-1:0] packet_data,
  output logic                  packet_valid,
  output logic [7:0]            packet_count,
  output logic                  error,
  output logic                  done
);

  localparam int unsigned CW = 8;
  localparam int unsigned PW = FLITS * SIZE;

`ifdef PACKET_SINK_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_HALT} state_t;

  state_t          r_state;
  logic            r_req_old;
  logic [CW-1:0]   r_flit_cnt;
  logic [CW-1:0]   r_delay;
  logic [PW-1:0]   r_buf;

  logic            w_req_event;
  logic            w_head;
  logic            w_drop;
  logic            w_frame_err;
  logic            w_complete;
  logic [CW-1:0]   w_idx;
  logic [CW-1:0]   w_count_inc;
  logic [PW-1:0]   w_buf_next;
  logic            w_unused_id;

  assign w_unused_id = ^32'(ID);

  assign w_req_event = req ^ r_req_old;
  assign w_head      = data[SIZE-1];
  assign w_drop      = !w_head && (r_flit_cnt == CW'(0));
  assign w_frame_err = w_drop || (w_head && (r_flit_cnt != CW'(0)));
  assign w_idx       = w_head ? CW'(0) : r_flit_cnt;
  assign w_complete  = !w_drop && (w_idx == CW'(FLITS - 1));
  assign w_count_inc = (packet_count == 8'hFF) ? packet_count : packet_count + 8'd1;

  // Buffer with the incoming flit written into its slot.
  always_comb begin
    w_buf_next = r_buf;
    for (int i = 0; i < int'(FLITS); i++) begin
      if (CW'(i) == w_idx) w_buf_next[i*SIZE +: SIZE] = data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_WAIT;
      r_req_old    <= 1'b0;
      r_flit_cnt   <= '0;
      r_delay      <= '0;
      r_buf        <= '0;
      ack          <= 1'b0;
      packet_data  <= '0;
      packet_valid <= 1'b0;
      packet_count <= '0;
      error        <= 1'b0;
      done         <= (PACKETS == 0);
    end else begin
      r_req_old    <= req;
      packet_valid <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (w_req_event) begin
            if (STRICT && w_frame_err) begin
              error   <= 1'b1;
              r_state <= S_HALT;
            end else begin
              if (w_frame_err) error <= 1'b1;
              if (!w_drop) begin
                r_buf <= w_buf_next;
                if (w_complete) begin
                  packet_data  <= w_buf_next;
                  packet_valid <= 1'b1;
                  packet_count <= w_count_inc;
                  r_flit_cnt   <= '0;
                  if (w_count_inc >= CW'(PACKETS)) done <= 1'b1;
                end else begin
                  r_flit_cnt <= w_idx + CW'(1);
                end
              end
              if (ACK_DELAY == 0) begin
                ack <= ~ack;
              end else begin
                r_delay <= CW'(ACK_DELAY);
                r_state <= S_HOLD;
              end
            end
          end
        end
        // A req toggle here means the source did not wait for ack.
        S_HOLD: begin
          if (STRICT && w_req_event) begin
            error   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            if (w_req_event) error <= 1'b1;
            r_delay <= r_delay - CW'(1);
            if (r_delay == CW'(1)) begin
              ack     <= ~ack;
              r_state <= S_WAIT;
            end
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_sink.sv
// Directed bench for packet_sink: zero-delay instance for framing/packets, ACK_DELAY=3 instance for hold timing.
module tb_packet_sink;

  localparam int TMO = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, req2 = 1'b0;
  logic [7:0]  data = '0, data2 = '0;
  logic        ack, ack2;
  logic [63:0] pd, pd2;
  logic        valid, valid2;
  logic [7:0]  cnt, cnt2;
  logic        err, err2;
  logic        done, done2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  packet_sink #(.ID(0), .FLITS(8), .SIZE(8), .PACKETS(2), .ACK_DELAY(0)) u_dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .ack(ack),
    .packet_data(pd), .packet_valid(valid), .packet_count(cnt), .error(err), .done(done));

  packet_sink #(.ID(1), .FLITS(8), .SIZE(8), .PACKETS(2), .ACK_DELAY(3)) u_dut_d3 (
    .clk(clk), .reset(reset), .req(req2), .data(data2), .ack(ack2),
    .packet_data(pd2), .packet_valid(valid2), .packet_count(cnt2), .error(err2), .done(done2));

  typedef struct {
    logic [7:0] d;
    logic       valid;
    logic [7:0] cnt;
    logic       err;
    logic       done;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = 1'b0; req2 = 1'b0; data = '0; data2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Toggle req with a flit, then count rising edges until ack toggles (TMO if it never does).
  task automatic send(input logic [7:0] d, input bit slow, output int lat);
    logic prev;
    @(negedge clk);
    if (slow) begin data2 = d; req2 = ~req2; prev = ack2; end
    else      begin data  = d; req  = ~req;  prev = ack;  end
    lat = 0;
    for (int i = 0; i < TMO; i++) begin
      @(posedge clk); #1;
      lat++;
      if ((slow ? ack2 : ack) != prev) break;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ack"},   64'(ack),   64'd0);
    check({tag, " pdata"}, pd,         64'd0);
    check({tag, " valid"}, 64'(valid), 64'd0);
    check({tag, " count"}, 64'(cnt),   64'd0);
    check({tag, " error"}, 64'(err),   64'd0);
    check({tag, " done"},  64'(done),  64'd0);
  endtask

  initial begin
    int lat;
    int pulses;

    tbl[0]  = '{8'h80, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h01, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[2]  = '{8'h02, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[3]  = '{8'h03, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[4]  = '{8'h04, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[5]  = '{8'h05, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[6]  = '{8'h06, 1'b0, 8'd0, 1'b0, 1'b0};
    tbl[7]  = '{8'h07, 1'b1, 8'd1, 1'b0, 1'b0};
    tbl[8]  = '{8'h88, 1'b0, 8'd1, 1'b0, 1'b0};
    tbl[9]  = '{8'h09, 1'b0, 8'd1, 1'b0, 1'b0};
    tbl[10] = '{8'h0A, 1'b0, 8'd1, 1'b0, 1'b0};
    tbl[11] = '{8'h0B, 1'b0, 8'd1, 1'b0, 1'b0};
    tbl[12] = '{8'h0C, 1'b0, 8'd1, 1'b0, 1'b0};
    tbl[13] = '{8'h0D, 1'b0, 8'd1, 1'b0, 1'b0};
    tbl[14] = '{8'h0E, 1'b0, 8'd1, 1'b0, 1'b0};
    tbl[15] = '{8'h0F, 1'b1, 8'd2, 1'b0, 1'b1};

    do_reset();
    check_reset_vals("rst");
    check("rst d3 ack", 64'(ack2), 64'd0);

    // Two back-to-back packets with zero ack delay.
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].d, 1'b0, lat);
      check($sformatf("v%0d lat", i),   64'(lat),   64'd1);
      check($sformatf("v%0d valid", i), 64'(valid), 64'(tbl[i].valid));
      check($sformatf("v%0d count", i), 64'(cnt),   64'(tbl[i].cnt));
      check($sformatf("v%0d error", i), 64'(err),   64'(tbl[i].err));
      check($sformatf("v%0d done", i),  64'(done),  64'(tbl[i].done));
      if (i == 7) check("pkt0 data", pd, 64'h0706050403020180);
    end
    check("pkt1 data", pd, 64'h0F0E0D0C0B0A0988);
    @(posedge clk); #1;
    check("valid one cycle", 64'(valid), 64'd0);

    // Packets after done still complete and count.
    for (int k = 0; k < 8; k++) send((k == 0) ? 8'hC0 : 8'(k), 1'b0, lat);
    check("post-done count", 64'(cnt),  64'd3);
    check("post-done done",  64'(done), 64'd1);
    check("post-done error", 64'(err),  64'd0);
    check("post-done data",  pd,        64'h07060504030201C0);

    // ACK_DELAY=3: ack after 4 edges counting the capture edge; toggle during HOLD is an error.
    send(8'h85, 1'b1, lat);
    check("d3 lat",   64'(lat),  64'd4);
    check("d3 error", 64'(err2), 64'd0);
    @(negedge clk); data2 = 8'h01; req2 = ~req2;
    @(negedge clk); data2 = 8'h02; req2 = ~req2;
    @(posedge clk); #1;
    check("d3 hold viol error", 64'(err2), 64'd1);
    check("d3 ack pending",     64'(ack2), 64'd1);
    repeat (2) @(posedge clk); #1;
    check("d3 ack after hold",  64'(ack2), 64'd0);
    check("d3 count",           64'(cnt2), 64'd0);

`ifdef PACKET_SINK_STRICT_EN
    do_reset();
    send(8'h12, 1'b0, lat);
    check("strict err", 64'(err), 64'd1);
    check("strict no ack", 64'(ack), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); data = (k == 0) ? 8'h80 : 8'(k); req = ~req;
    end
    repeat (3) @(posedge clk); #1;
    check("strict ack frozen", 64'(ack),  64'd0);
    check("strict count",      64'(cnt),  64'd0);
    check("strict done",       64'(done), 64'd0);
`else
    // Missing head: flagged, acked, dropped; next packet still frames correctly.
    do_reset();
    send(8'h12, 1'b0, lat);
    check("nohead lat",   64'(lat), 64'd1);
    check("nohead error", 64'(err), 64'd1);
    for (int k = 0; k < 8; k++) begin
      send((k == 0) ? 8'h80 : 8'(k), 1'b0, lat);
      check($sformatf("nohead f%0d valid", k), 64'(valid), 64'(k == 7));
    end
    check("nohead count", 64'(cnt), 64'd1);
    check("nohead data",  pd,       64'h0706050403020180);

    // Premature head restarts the packet.
    do_reset();
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      send((k == 0) ? 8'h80 : (k < 4) ? 8'(k) : (k == 4) ? 8'h81 : 8'(k - 4), 1'b0, lat);
      if (valid) pulses++;
    end
    check("prem error",  64'(err),    64'd1);
    check("prem pulses", 64'(pulses), 64'd1);
    check("prem data",   pd,          64'h0706050403020181);
    check("prem count",  64'(cnt),    64'd1);
`endif

    // Reset mid-packet discards partial flits.
    for (int k = 0; k < 4; k++) send((k == 0) ? 8'h80 : 8'(k), 1'b0, lat);
    do_reset();
    check_reset_vals("midrst");
    for (int k = 0; k < 8; k++) send((k == 0) ? 8'hA0 : 8'(k + 16), 1'b0, lat);
    check("midrst count", 64'(cnt),   64'd1);
    check("midrst valid", 64'(valid), 64'd1);
    check("midrst data",  pd,         64'h17161514131211A0);
    check("midrst error", 64'(err),   64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
